// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets, STATUS/CTRL bit positions and the parity helper.
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_CTRL   = 4'h8;

  localparam int unsigned ST_BUSY       = 0;
  localparam int unsigned ST_FULL       = 1;
  localparam int unsigned ST_EMPTY      = 2;
  localparam int unsigned ST_OVF        = 3;
  localparam int unsigned ST_COUNT_LSB  = 4;
  localparam int unsigned ST_PARITY_CAP = 8;

  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART register window.
interface mmio_uart_tx_if;
  logic        wr_sig;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;

  modport master (output wr_sig, addr, wr_data, input rd_data, hit);
  modport slave  (input wr_sig, addr, wr_data, output rd_data, hit);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Circular synchronous FIFO with push/pop/flush and occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and STATUS/CTRL registers.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    word;
  logic          wr_txdata;
  logic          wr_ctrl;
  logic          flush;
  logic          clr_ovf;
  logic          pop;
  logic          ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rd;
  logic [31:0]   status;
  logic          unused_bits;

  uart_state_e   state, state_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par, par_nx;
`endif

  // The window is word-aligned, so the low address nibble selects the register.
  assign word      = bus.addr[3:2] - BASE_ADDR[3:2];
  assign bus.hit   = (bus.addr >= BASE_ADDR) && (bus.addr <= BASE_ADDR + 32'd8);
  assign wr_txdata = bus.wr_sig && bus.hit && (word == UART_TXDATA[3:2]);
  assign wr_ctrl   = bus.wr_sig && bus.hit && (word == UART_CTRL[3:2]);
  assign flush     = wr_ctrl && bus.wr_data[CTRL_FLUSH];
  assign clr_ovf   = wr_ctrl && bus.wr_data[CTRL_CLR_OVF];
  assign unused_bits = ^bus.wr_data[31:8];

  // A flush on the same edge must not let the FSM grab a byte being discarded.
  assign pop = (state == UART_IDLE) && !fifo_empty && !flush;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_txdata),
    .pop     (pop),
    .flush   (flush),
    .wr_data (bus.wr_data[7:0]),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else if (wr_txdata && fifo_full && !pop && !flush) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    status                        = '0;
    status[ST_BUSY]               = (state != UART_IDLE);
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_OVF]                = ovf;
    status[ST_COUNT_LSB +: 4]     = 4'(fifo_count);
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY_CAP]         = 1'b1;
`endif
  end

  assign bus.rd_data = (bus.hit && (word == UART_STATUS[3:2])) ? status : '0;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= UART_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
`ifdef UART_TX_PARITY_EN
      par     <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    baud_nx    = baud + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
`ifdef UART_TX_PARITY_EN
    par_nx     = par;
`endif
    case (state)
      UART_IDLE: begin
        baud_nx = '0;
        if (pop) begin
          shift_nx   = fifo_rd;
          bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
          par_nx     = even_parity(fifo_rd);
`endif
          state_nx   = UART_START;
        end
      end
      UART_START: begin
        if (bit_end) begin
          baud_nx  = '0;
          state_nx = UART_DATA;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          baud_nx    = '0;
          shift_nx   = shift >> 1;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = UART_PARITY;
`else
            state_nx = UART_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_PARITY: begin
        if (bit_end) begin
          baud_nx  = '0;
          state_nx = UART_STOP;
        end
      end
`endif
      UART_STOP: begin
        if (bit_end) begin
          baud_nx  = '0;
          state_nx = UART_IDLE;
        end
      end
      default: begin
        baud_nx  = '0;
        state_nx = UART_IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      UART_START:  tx = 1'b0;
      UART_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
      UART_PARITY: tx = par;
`endif
      default:     tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME = 44;
  localparam logic [31:0] CAP   = 32'h0000_0100;
`else
  localparam int unsigned FRAME = 40;
  localparam logic [31:0] CAP   = 32'h0000_0000;
`endif

  logic clk;
  logic reset_n;
  logic tx;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0] rx_q[$];

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT(4),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Call at a negedge; the write is sampled on the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr_sig  = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_sig  = 1'b0;
    bus.addr    = BASE + 32'd4;
    bus.wr_data = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.addr = BASE + 32'd4;
    #1;
    v = bus.rd_data;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p);
    logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, p, d, 1'b0};
`else
    bits = {p, 1'b1, d, 1'b0};
`endif
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk);
      check("frame_tx", tx, bits[i / 4]);
      check("frame_busy", bus.rd_data[0], 1);
    end
    @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", bus.rd_data[0], 0);
  endtask

  // Line receiver: samples mid-bit from the first low sample of the start bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        repeat (6) @(negedge clk);
        b[0] = tx;
        for (int j = 1; j < 8; j++) begin
          repeat (4) @(negedge clk);
          b[j] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (4) @(negedge clk);
`endif
        repeat (4) @(negedge clk);
        check("rx_stop", tx, 1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic [7:0]  exp_b [6];
    int unsigned lows;

    reset_n     = 1'b0;
    bus.wr_sig  = 1'b0;
    bus.addr    = BASE + 32'd4;
    bus.wr_data = '0;
    #1;
    check("reset_tx", tx, 1);
    read_status(s);
    check("reset_status", s, 32'h4 | CAP);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single byte: exact waveform and busy window.
    bus_write(BASE, 32'h55);
    read_status(s);
    check("t1_status", s, 32'h10 | CAP);
    expect_frame(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    rx_q.delete();

    // Back-to-back writes: A1 pops on the second edge, so E5 fits; F6 overflows.
    bus_write(BASE, 32'hA1);
    bus_write(BASE, 32'hB2);
    bus_write(BASE, 32'hC3);
    bus_write(BASE, 32'hD4);
    bus_write(BASE, 32'hE5);
    read_status(s);
    check("t2_full", s, 32'h43 | CAP);
    bus_write(BASE, 32'hF6);
    read_status(s);
    check("t2_ovf", s, 32'h4B | CAP);
    // Land a write on the edge where the FSM pops the next byte: accepted while full.
    repeat (FRAME - 4) @(negedge clk);
    bus_write(BASE, 32'h99);
    read_status(s);
    check("t2_pop_push", s, 32'h4B | CAP);
    for (int c = 0; c < 800 && rx_q.size() < 6; c++) @(negedge clk);
    check("t2_rx_count", rx_q.size(), 6);
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h99};
    for (int i = 0; i < 6; i++)
      check("t2_rx_byte", (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, {24'h0, exp_b[i]});
    repeat (4) @(negedge clk);
    read_status(s);
    check("t2_done", s, 32'h0C | CAP);

    // Clear overflow.
    bus_write(BASE + 32'd8, 32'h1);
    read_status(s);
    check("t3_clr_ovf", s, 32'h04 | CAP);

    // Flush with three queued: in-flight frame completes, nothing else.
    rx_q.delete();
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    bus_write(BASE, 32'h44);
    read_status(s);
    check("t4_queued", s, 32'h31 | CAP);
    bus_write(BASE + 32'd8, 32'h2);
    read_status(s);
    check("t4_flushed", s, 32'h05 | CAP);
    repeat (FRAME + 60) @(negedge clk);
    check("t4_rx_count", rx_q.size(), 1);
    check("t4_rx_byte", (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hDEAD, 32'h11);
    read_status(s);
    check("t4_idle", s, 32'h04 | CAP);

    // Address decode.
    bus.addr = 32'h0000_0100; #1;
    check("dec_out_hit", bus.hit, 0);
    check("dec_out_rd", bus.rd_data, 0);
    bus.addr = BASE + 32'd4; #1;
    check("dec_st_hit", bus.hit, 1);
    check("dec_st_rd", bus.rd_data, 32'h04 | CAP);
    bus.addr = BASE; #1;
    check("dec_tx_hit", bus.hit, 1);
    check("dec_tx_rd", bus.rd_data, 0);
    bus.addr = BASE + 32'd8; #1;
    check("dec_ctrl_hit", bus.hit, 1);
    check("dec_ctrl_rd", bus.rd_data, 0);
    bus.addr = BASE + 32'd12; #1;
    check("dec_above_hit", bus.hit, 0);
    bus.addr = BASE - 32'd4; #1;
    check("dec_below_hit", bus.hit, 0);
    bus.addr = BASE + 32'd4;
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    bus_write(BASE, 32'h07);
    expect_frame(8'h07, 1'b1);
    @(negedge clk);
    bus_write(BASE, 32'h03);
    expect_frame(8'h03, 1'b0);
    @(negedge clk);
`endif

    // Reset in the middle of DATA with a second byte queued.
    bus_write(BASE, 32'hF0);
    bus_write(BASE, 32'h0F);
    repeat (8) @(negedge clk);
    check("pre_reset_tx", tx, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    read_status(s);
    check("in_reset_status", s, 32'h04 | CAP);
    @(negedge clk);
    reset_n = 1'b1;
    read_status(s);
    check("post_reset_status", s, 32'h04 | CAP);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_reset_quiet", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
